// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the execute stage.
// Accepts one mult/multu/div/divu issue, computes the result into pending
// registers, counts down a fixed latency, and then commits the result to HI/LO.
// While the operation runs, D-stage HI/LO users are stalled.
// Optional feature macro: MD_DIVZERO_FLAG_EN adds a sticky divide-by-zero
// flag output `dz`.
module md_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        md_in_d,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        done
`ifdef MD_DIVZERO_FLAG_EN
   ,
   output logic        dz
`endif
);

   logic [3:0]  count;
   logic [3:0]  count_nxt;
   logic        done_nxt;
   logic [3:0]  load_cnt;
   logic        accept;
   logic        commit;
   logic        mt_ok;
   logic [63:0] result;
   logic [31:0] hi_p;
   logic [31:0] lo_p;

   // Produces {hi, lo} for the selected operation. Division is done on
   // magnitudes so the -2^31 / -1 case wraps to 32'h8000_0000 with a zero
   // remainder instead of relying on tool behaviour for signed overflow.
   // A zero divisor yields lo = all ones and hi = dividend, never X.
   function automatic logic [63:0] md_compute(input logic [1:0]  f_op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [63:0] prod_s;
      logic [63:0]        prod_u;
      logic [31:0]        a_mag;
      logic [31:0]        b_mag;
      logic [31:0]        q_mag;
      logic [31:0]        r_mag;
      logic [31:0]        q;
      logic [31:0]        r;
      logic               is_signed;
      logic               neg_q;
      logic               neg_r;
      logic [63:0]        res;

      prod_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u    = {32'd0, a} * {32'd0, b};
      is_signed = ~f_op[0];
      neg_q     = is_signed & (a[31] ^ b[31]);
      neg_r     = is_signed & a[31];
      a_mag     = (is_signed & a[31]) ? (~a + 32'd1) : a;
      b_mag     = (is_signed & b[31]) ? (~b + 32'd1) : b;
      q_mag     = 32'd0;
      r_mag     = 32'd0;
      q         = 32'hFFFF_FFFF;
      r         = a;
      if (b != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
         q     = neg_q ? (~q_mag + 32'd1) : q_mag;
         r     = neg_r ? (~r_mag + 32'd1) : r_mag;
      end
      case (f_op)
         2'b00:   res = $unsigned(prod_s);
         2'b01:   res = prod_u;
         default: res = {r, q};
      endcase
      return res;
   endfunction

   assign busy     = (count != 4'd0);
   assign accept   = start & ~busy;
   assign commit   = (count == 4'd1);
   assign mt_ok    = ~busy & ~start;
   assign stall    = md_in_d & (busy | start);
   assign load_cnt = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
   assign result   = md_compute(op, rs_val, rt_val);

   // Next-state logic for the latency counter and the done pulse.
   always_comb begin
      count_nxt = count;
      done_nxt  = 1'b0;
      if (accept) begin
         count_nxt = load_cnt;
      end else if (busy) begin
         count_nxt = count - 4'd1;
         done_nxt  = commit;
      end
   end

   // Counter (state) and done register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 4'd0;
         done  <= 1'b0;
      end else begin
         count <= count_nxt;
         done  <= done_nxt;
      end
   end

   // Pending result captured at issue; discarded on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_p <= 32'd0;
         lo_p <= 32'd0;
      end else if (accept) begin
         hi_p <= result[63:32];
         lo_p <= result[31:0];
      end
   end

   // HI/LO architectural registers: commit from pending, or mthi/mtlo when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (commit) begin
         hi <= hi_p;
         lo <= lo_p;
      end else if (mt_ok) begin
         if (mthi) hi <= rs_val;
         if (mtlo) lo <= rs_val;
      end
   end

`ifdef MD_DIVZERO_FLAG_EN
   logic dz_p;

   // Sticky divide-by-zero flag: marked at issue, raised at commit,
   // cleared by an accepted mthi/mtlo.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dz_p <= 1'b0;
         dz   <= 1'b0;
      end else begin
         if (accept) dz_p <= op[1] & (rt_val == 32'd0);
         if (commit && dz_p) begin
            dz <= 1'b1;
         end else if (mt_ok && (mthi || mtlo)) begin
            dz <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched.
// Build with MD_DIVZERO_FLAG_EN defined to also check the dz flag.
module tb_md_sched;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        start   = 1'b0;
   logic [1:0]  op      = 2'b00;
   logic [31:0] rs_val  = 32'd0;
   logic [31:0] rt_val  = 32'd0;
   logic        mthi    = 1'b0;
   logic        mtlo    = 1'b0;
   logic        md_in_d = 1'b0;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;
`ifdef MD_DIVZERO_FLAG_EN
   logic        dz;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .mthi    (mthi),
      .mtlo    (mtlo),
      .md_in_d (md_in_d),
      .busy    (busy),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo),
      .done    (done)
`ifdef MD_DIVZERO_FLAG_EN
      ,
      .dz      (dz)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, check busy for n cycles, end in the done cycle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      step();
      start = 1'b0;
      #1;
      for (int i = 0; i < n; i++) begin
         chk({tag, " busy"}, 32'(busy), 32'd1);
         step();
      end
      chk({tag, " busy end"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
   endtask

   initial begin
      // reset state
      repeat (2) step();
      md_in_d = 1'b1;
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      reset = 1'b1;
      step();

      // mult -2 * 3 with md_in_d held high
      start = 1'b1; op = 2'b00; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
      #1;
      chk("mult stall start", 32'(stall), 32'd1);
      step();
      start = 1'b0;
      #1;
      for (int i = 0; i < MC; i++) begin
         chk("mult busy", 32'(busy), 32'd1);
         chk("mult stall busy", 32'(stall), 32'd1);
         chk("mult done early", 32'(done), 32'd0);
         chk("mult hi hold", hi, 32'd0);
         step();
      end
      chk("mult busy end", 32'(busy), 32'd0);
      chk("mult done", 32'(done), 32'd1);
      chk("mult stall done", 32'(stall), 32'd0);
      chk("mult hi", hi, 32'hFFFF_FFFF);
      chk("mult lo", lo, 32'hFFFF_FFFA);
      step();
      chk("mult done once", 32'(done), 32'd0);
      md_in_d = 1'b0;

      // divu 100/7 issued together with mthi/mtlo; start while busy is ignored
      start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; mthi = 1'b1; mtlo = 1'b1;
      step();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      #1;
      chk("start beats mthi", hi, 32'hFFFF_FFFF);
      chk("start beats mtlo", lo, 32'hFFFF_FFFA);
      for (int i = 0; i < DC; i++) begin
         chk("divu busy", 32'(busy), 32'd1);
         if (i == 3) begin
            start = 1'b1; op = 2'b01; rs_val = 32'd9; rt_val = 32'd9; mthi = 1'b1;
         end
         step();
         start = 1'b0; mthi = 1'b0;
         #1;
      end
      chk("divu busy end", 32'(busy), 32'd0);
      chk("divu done", 32'(done), 32'd1);
      chk("divu lo", lo, 32'd14);
      chk("divu hi", hi, 32'd2);

      // back-to-back multu 2*3 issued in the done cycle
      run_op("b2b multu", 2'b01, 32'd2, 32'd3, MC, 32'd0, 32'd6);
      step();

      // div -7 / 2
      run_op("div neg", 2'b10, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      step();

      // div 5 / 0
      run_op("div zero", 2'b10, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF);
`ifdef MD_DIVZERO_FLAG_EN
      chk("dz set", 32'(dz), 32'd1);
`endif
      step();
      mtlo = 1'b1; rs_val = 32'h0000_1234;
      step();
      mtlo = 1'b0;
      #1;
      chk("mtlo lo", lo, 32'h0000_1234);
      chk("mtlo hi kept", hi, 32'd5);
      chk("mtlo no done", 32'(done), 32'd0);
`ifdef MD_DIVZERO_FLAG_EN
      chk("dz clear", 32'(dz), 32'd0);
`endif

      // divu by zero
      run_op("divu zero", 2'b11, 32'hDEAD_BEEF, 32'd0, DC, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      step();

      // div overflow case
      run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
      step();

      // mthi in idle
      mthi = 1'b1; rs_val = 32'hAAAA_5555;
      step();
      mthi = 1'b0;
      #1;
      chk("mthi hi", hi, 32'hAAAA_5555);
      chk("mthi lo kept", lo, 32'h8000_0000);
      chk("mthi no done", 32'(done), 32'd0);

      // reset in the middle of mult 3*4
      start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd4;
      step();
      start = 1'b0;
      step();
      chk("pre-rst busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst hi", hi, 32'd0);
      chk("mid rst lo", lo, 32'd0);
      chk("mid rst done", 32'(done), 32'd0);
      step();
      reset = 1'b1;
      repeat (6) step();
      chk("post rst busy", 32'(busy), 32'd0);
      chk("post rst hi", hi, 32'd0);
      chk("post rst lo", lo, 32'd0);
      chk("post rst done", 32'(done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
